img_frame_sequencer: RTL and testbench

//  Sequences the pixel-pair image source and the BMP sink for multi-frame runs. Issues a frame-start pulse,

---
 rtl/img_pkg.sv | 22 ++
 rtl/img_line_checker.sv | 67 ++++++
 rtl/img_frame_sequencer.sv | 140 ++++++++++++++
 tb/tb_img_frame_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared state and op-mode types for the image frame sequencer, source and sink
package img_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_V,
    ST_ACTIVE,
    ST_CHECK,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  typedef enum logic [1:0] {
    OP_BYPASS = 2'd0,
    OP_BRIGHT = 2'd1,
    OP_INVERT = 2'd2,
    OP_THRESH = 2'd3
  } op_mode_t;

endpackage

// File: rtl/img_line_checker.sv
// rtl/img_line_checker.sv - hsync edge detect, pair/line counters and geometry error flagging
module img_line_checker #(
  parameter int PAIRS = 384,
  parameter int LINES = 512
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         clear,
  input  logic                         en,
  input  logic                         hsync,
  input  logic                         done,
  output logic [$clog2(PAIRS+1)-1:0]   pair_cnt,
  output logic [$clog2(LINES+1)-1:0]   line_cnt,
  output logic                         hs_edge,
  output logic                         line_err,
  output logic                         bad
);

  localparam int PW = $clog2(PAIRS + 1);
  localparam int LW = $clog2(LINES + 1);

  logic hs_prev;
  logic fall;
  logic pair_inc;
  logic pair_full;
  logic lines_full;

  assign hs_edge    = hsync ^ hs_prev;
  assign fall       = hs_prev & ~hsync;
  assign pair_inc   = hsync | done;
  assign pair_full  = (pair_cnt == PW'(PAIRS));
  assign lines_full = (line_cnt == LW'(LINES));

  // Counters never pass PAIRS / LINES: an extra pair or line is flagged instead of wrapping.
  assign line_err = en & ((pair_inc & pair_full) |
                          (fall & (~pair_full | lines_full)) |
                          (done & lines_full));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hs_prev  <= 1'b0;
      pair_cnt <= '0;
      line_cnt <= '0;
      bad      <= 1'b0;
    end else begin
      hs_prev <= hsync;
      if (clear) begin
        pair_cnt <= '0;
        line_cnt <= '0;
        bad      <= 1'b0;
      end else if (en) begin
        if (line_err) bad <= 1'b1;
        // The done cycle is the final pair and closes the last line without zeroing its pair count.
        if (done) begin
          if (!pair_full)  pair_cnt <= pair_cnt + PW'(1);
          if (!lines_full) line_cnt <= line_cnt + LW'(1);
        end else if (fall) begin
          pair_cnt <= '0;
          if (!lines_full) line_cnt <= line_cnt + LW'(1);
        end else if (hsync && !pair_full) begin
          pair_cnt <= pair_cnt + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/img_frame_sequencer.sv
// rtl/img_frame_sequencer.sv - multi-frame run sequencer between config layer, pixel-pair source and BMP sink
module img_frame_sequencer
  import img_pkg::*;
#(
  parameter int WIDTH   = 768,
  parameter int HEIGHT  = 512,
  parameter int GAP_CYC = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       cfg_start,
  input  logic [7:0] cfg_frames,
  input  logic [1:0] cfg_op_mode,
  input  logic       cfg_abort,
  input  logic       src_vsync,
  input  logic       src_hsync,
  input  logic       src_done,
  output logic       src_start,
  output logic [1:0] op_mode,
  output logic       sink_en,
  output logic       frame_done,
  output logic       run_done,
  output logic       busy,
  output logic       err_geom,
  output logic       err_timeout,
  output logic [7:0] frame_idx
);

  localparam int PAIRS = WIDTH / 2;
  localparam int PW    = $clog2(PAIRS + 1);
  localparam int LW    = $clog2(HEIGHT + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int GW    = $clog2(GAP_CYC + 1);

  seq_state_t        state, state_n;
  op_mode_t          op_q;
  logic [7:0]        frames_q;
  logic [TW-1:0]     tmo_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              vs_prev;
  logic [PW-1:0]     pair_cnt;
  logic [LW-1:0]     line_cnt;
  logic              hs_edge, line_err, bad;
  logic              vs_fall, tmo_hit, geom_ok, last_frame, gap_last, accept;
  logic              set_geom, set_tmo;

  img_line_checker #(.PAIRS(PAIRS), .LINES(HEIGHT)) u_line_checker (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .clear    (state == ST_LAUNCH),
    .en       (state == ST_ACTIVE),
    .hsync    (src_hsync),
    .done     (src_done),
    .pair_cnt (pair_cnt),
    .line_cnt (line_cnt),
    .hs_edge  (hs_edge),
    .line_err (line_err),
    .bad      (bad)
  );

  assign vs_fall    = vs_prev & ~src_vsync;
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT));
  assign geom_ok    = !bad && (line_cnt == LW'(HEIGHT)) && (pair_cnt == PW'(PAIRS));
  assign last_frame = ({1'b0, frame_idx} + 9'd1) == {1'b0, frames_q};
  assign gap_last   = (state == ST_GAP) && (gap_cnt == GW'(GAP_CYC - 1)) && !cfg_abort;
  assign accept     = cfg_start && !cfg_abort && (state == ST_IDLE || state == ST_ERROR);

  always_comb begin
    state_n  = state;
    set_geom = 1'b0;
    set_tmo  = 1'b0;
    case (state)
      ST_IDLE:   if (cfg_start) state_n = ST_LAUNCH;
      ST_LAUNCH: state_n = ST_WAIT_V;
      ST_WAIT_V: begin
        if (vs_fall) state_n = ST_ACTIVE;
        else if (tmo_hit) begin state_n = ST_ERROR; set_tmo = 1'b1; end
      end
      // src_done outranks both a same-cycle geometry slip (caught via bad in CHECK) and a timeout.
      ST_ACTIVE: begin
        if (src_done) state_n = ST_CHECK;
        else if (line_err) begin state_n = ST_ERROR; set_geom = 1'b1; end
        else if (tmo_hit) begin state_n = ST_ERROR; set_tmo = 1'b1; end
      end
      ST_CHECK: begin
        if (geom_ok) state_n = last_frame ? ST_DONE : ST_GAP;
        else begin state_n = ST_ERROR; set_geom = 1'b1; end
      end
      ST_GAP:   if (gap_last) state_n = ST_LAUNCH;
      ST_DONE:  state_n = ST_IDLE;
      ST_ERROR: if (cfg_start) state_n = ST_LAUNCH;
      default:  state_n = ST_IDLE;
    endcase
    if (cfg_abort) begin
      state_n  = ST_IDLE;
      set_geom = 1'b0;
      set_tmo  = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      op_q        <= OP_BYPASS;
      frames_q    <= 8'd0;
      frame_idx   <= 8'd0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      vs_prev     <= 1'b0;
      err_geom    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state   <= state_n;
      vs_prev <= src_vsync;
      if (state == ST_LAUNCH) op_q <= op_mode_t'(cfg_op_mode);
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
      if (state == ST_LAUNCH || hs_edge || (vs_prev ^ src_vsync)) tmo_cnt <= '0;
      else if ((state == ST_WAIT_V || state == ST_ACTIVE) && !tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
      if (accept) begin
        frames_q    <= (cfg_frames == 8'd0) ? 8'd1 : cfg_frames;
        frame_idx   <= 8'd0;
        err_geom    <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (set_geom) err_geom <= 1'b1;
        if (set_tmo) err_timeout <= 1'b1;
        if (gap_last) frame_idx <= frame_idx + 8'd1;
      end
    end
  end

  assign src_start  = (state == ST_LAUNCH);
  assign sink_en    = (state == ST_ACTIVE);
  assign frame_done = (state == ST_CHECK) && geom_ok;
  assign run_done   = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign op_mode    = op_q;

endmodule

// File: tb/tb_img_frame_sequencer.sv
// tb/tb_img_frame_sequencer.sv - directed, table-driven self-checking bench for img_frame_sequencer
module tb_img_frame_sequencer;

  localparam int W = 8;
  localparam int H = 4;
  localparam int G = 3;
  localparam int TO = 50;
  localparam int PAIRS = W / 2;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       cfg_start = 1'b0;
  logic [7:0] cfg_frames = 8'd0;
  logic [1:0] cfg_op_mode = 2'd0;
  logic       cfg_abort = 1'b0;
  logic       src_vsync = 1'b0;
  logic       src_hsync = 1'b0;
  logic       src_done = 1'b0;
  logic       src_start, sink_en, frame_done, run_done, busy, err_geom, err_timeout;
  logic [1:0] op_mode;
  logic [7:0] frame_idx;

  always #5 HCLK = ~HCLK;

  img_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .GAP_CYC(G), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cfg_start(cfg_start), .cfg_frames(cfg_frames),
    .cfg_op_mode(cfg_op_mode), .cfg_abort(cfg_abort), .src_vsync(src_vsync),
    .src_hsync(src_hsync), .src_done(src_done), .src_start(src_start), .op_mode(op_mode),
    .sink_en(sink_en), .frame_done(frame_done), .run_done(run_done), .busy(busy),
    .err_geom(err_geom), .err_timeout(err_timeout), .frame_idx(frame_idx)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0, rd_cnt = 0, fd_cyc = 0, rd_cyc = 0;
  int start_cyc[$];
  int start_idx[$];
  int done_cyc = 0;

  always @(negedge HCLK) begin
    cyc = cyc + 1;
    if (frame_done === 1'b1) begin fd_cnt = fd_cnt + 1; fd_cyc = cyc; end
    if (run_done === 1'b1) begin rd_cnt = rd_cnt + 1; rd_cyc = cyc; end
    if (src_start === 1'b1) begin start_cyc.push_back(cyc); start_idx.push_back(int'(frame_idx)); end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic launch_vsync(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (src_start === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    chk("src_start_seen", {31'd0, ok}, 32'd1);
    if (ok) begin
      src_vsync = 1'b1;
      tick();
      tick();
      src_vsync = 1'b0;
      tick();
    end
  endtask

  task automatic pair(input logic d);
    src_hsync = 1'b1;
    src_done = d;
    tick();
    src_hsync = 1'b0;
    src_done = 1'b0;
  endtask

  task automatic frame(input int bad_line, input int bad_pairs, input int exp_mode, input int poke_line);
    bit ok;
    int n;
    launch_vsync(ok);
    if (!ok) return;
    for (int l = 0; l < H; l++) begin
      n = (l == bad_line) ? bad_pairs : PAIRS;
      for (int p = 0; p < n; p++) begin
        if (l == poke_line && p == 0) begin
          cfg_start = 1'b1; cfg_op_mode = 2'd3; cfg_frames = 8'd1;
        end else begin
          cfg_start = 1'b0;
        end
        if (l == H - 1 && p == n - 1) begin
          done_cyc = cyc + 1;
          chk("op_mode_in_frame", 32'(op_mode), 32'(exp_mode));
        end
        pair(l == H - 1 && p == n - 1);
      end
      cfg_start = 1'b0;
      tick();
    end
  endtask

  typedef struct {
    int frames; int mode; int src_frames; int bad_line; int bad_pairs;
    int exp_fd; int exp_rd; int exp_geom; int exp_busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int fd0, rd0, s0, ns;
    bit ok;

    vecs[0] = '{frames: 1, mode: 0, src_frames: 1, bad_line: -1, bad_pairs: 0, exp_fd: 1, exp_rd: 1, exp_geom: 0, exp_busy: 0};
    vecs[1] = '{frames: 3, mode: 2, src_frames: 3, bad_line: -1, bad_pairs: 0, exp_fd: 3, exp_rd: 1, exp_geom: 0, exp_busy: 0};
    vecs[2] = '{frames: 1, mode: 1, src_frames: 1, bad_line: 1, bad_pairs: 3, exp_fd: 0, exp_rd: 0, exp_geom: 1, exp_busy: 1};
    vecs[3] = '{frames: 0, mode: 3, src_frames: 1, bad_line: -1, bad_pairs: 0, exp_fd: 1, exp_rd: 1, exp_geom: 0, exp_busy: 0};
    vecs[4] = '{frames: 1, mode: 1, src_frames: 1, bad_line: 3, bad_pairs: 5, exp_fd: 0, exp_rd: 0, exp_geom: 1, exp_busy: 1};
    vecs[5] = '{frames: 2, mode: 1, src_frames: 2, bad_line: -1, bad_pairs: 0, exp_fd: 2, exp_rd: 1, exp_geom: 0, exp_busy: 0};

    repeat (3) tick();
    chk("reset_outputs", 32'({src_start, op_mode, sink_en, frame_done, run_done, busy, err_geom, err_timeout, frame_idx}), 32'd0);
    HRESETn = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 6; v++) begin
      fd0 = fd_cnt; rd0 = rd_cnt; s0 = start_cyc.size();
      cfg_frames = 8'(vecs[v].frames);
      cfg_op_mode = 2'(vecs[v].mode);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      for (int f = 0; f < vecs[v].src_frames; f++)
        frame((f == 0) ? vecs[v].bad_line : -1, vecs[v].bad_pairs, vecs[v].mode, -1);
      repeat (8) tick();
      ns = start_cyc.size() - s0;
      chk($sformatf("v%0d_frame_done", v), 32'(fd_cnt - fd0), 32'(vecs[v].exp_fd));
      chk($sformatf("v%0d_run_done", v), 32'(rd_cnt - rd0), 32'(vecs[v].exp_rd));
      chk($sformatf("v%0d_err_geom", v), 32'(err_geom), 32'(vecs[v].exp_geom));
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
      chk($sformatf("v%0d_err_timeout", v), 32'(err_timeout), 32'd0);
      chk($sformatf("v%0d_starts", v), 32'(ns), 32'(vecs[v].src_frames));
      for (int i = 0; i < ns; i++) begin
        chk($sformatf("v%0d_start_idx%0d", v, i), 32'(start_idx[s0 + i]), 32'(i));
        if (i > 0)
          chk($sformatf("v%0d_start_gap%0d", v, i), 32'(start_cyc[s0 + i] - start_cyc[s0 + i - 1] > G), 32'd1);
      end
      if (vecs[v].exp_rd == 1) begin
        chk($sformatf("v%0d_fd_latency", v), 32'(fd_cyc - done_cyc), 32'd1);
        chk($sformatf("v%0d_rd_latency", v), 32'(rd_cyc - done_cyc), 32'd2);
      end
    end

    // Source stalls after vsync: timeout must fire after ~TO cycles, not before, and hold until abort.
    cfg_frames = 8'd1; cfg_op_mode = 2'd0; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    launch_vsync(ok);
    repeat (45) tick();
    chk("tmo_not_early", 32'(err_timeout), 32'd0);
    chk("tmo_busy_early", 32'(busy), 32'd1);
    repeat (15) tick();
    chk("tmo_flag", 32'(err_timeout), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd1);
    chk("tmo_sink_off", 32'(sink_en), 32'd0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("tmo_abort_idle", 32'(busy), 32'd0);
    chk("tmo_sticky", 32'(err_timeout), 32'd1);

    // Abort in the middle of the third line.
    fd0 = fd_cnt; rd0 = rd_cnt;
    cfg_frames = 8'd1; cfg_op_mode = 2'd1; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("start_clears_tmo", 32'(err_timeout), 32'd0);
    launch_vsync(ok);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < PAIRS; p++) pair(1'b0);
      tick();
    end
    pair(1'b0);
    pair(1'b0);
    src_hsync = 1'b1;
    cfg_abort = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sink_en", 32'(sink_en), 32'd0);
    cfg_abort = 1'b0;
    src_hsync = 1'b0;
    repeat (10) tick();
    chk("abort_no_fd", 32'(fd_cnt - fd0), 32'd0);
    chk("abort_no_rd", 32'(rd_cnt - rd0), 32'd0);

    // Asynchronous reset while ACTIVE.
    cfg_frames = 8'd2; cfg_op_mode = 2'd2; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    launch_vsync(ok);
    for (int p = 0; p < PAIRS; p++) pair(1'b0);
    chk("pre_reset_sink_en", 32'(sink_en), 32'd1);
    chk("pre_reset_op_mode", 32'(op_mode), 32'd2);
    #2 HRESETn = 1'b0;
    #1 chk("reset_active_outputs", 32'({src_start, op_mode, sink_en, frame_done, run_done, busy, err_geom, err_timeout, frame_idx}), 32'd0);
    repeat (2) tick();
    HRESETn = 1'b1;
    tick();

    // cfg_start and a mode change while busy: run continues, new mode only at the next launch.
    fd0 = fd_cnt; rd0 = rd_cnt; s0 = start_cyc.size();
    cfg_frames = 8'd2; cfg_op_mode = 2'd1; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    frame(-1, 0, 1, 1);
    frame(-1, 0, 3, -1);
    repeat (8) tick();
    chk("busy_start_fd", 32'(fd_cnt - fd0), 32'd2);
    chk("busy_start_rd", 32'(rd_cnt - rd0), 32'd1);
    chk("busy_start_starts", 32'(start_cyc.size() - s0), 32'd2);
    if (start_cyc.size() - s0 >= 2)
      chk("busy_start_idx1", 32'(start_idx[s0 + 1]), 32'd1);
    chk("busy_start_final_mode", 32'(op_mode), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
